// File: rtl/rf_xfer_ctrl_pkg.sv
// Shared definitions for the register-file transfer controller:
// register codes, command opcodes and controller state encoding.
package rf_xfer_ctrl_pkg;

    localparam logic [2:0] REG_A = 3'd0;
    localparam logic [2:0] REG_B = 3'd1;
    localparam logic [2:0] REG_C = 3'd2;
    localparam logic [2:0] REG_D = 3'd3;
    localparam logic [2:0] REG_F = 3'd4;
    localparam logic [2:0] FREG  = REG_F;

    localparam logic [1:0] OP_MOV = 2'd0;
    localparam logic [1:0] OP_LDI = 2'd1;
    localparam logic [1:0] OP_RD  = 2'd2;
    localparam logic [1:0] OP_SWP = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StRdSrc,
        StRdDst,
        StWrDst,
        StWrSrc,
        StDone
    } state_e;

    function automatic logic reg_legal(input logic [2:0] code);
        return code <= REG_F;
    endfunction

endpackage

// File: rtl/rf_sel_decode.sv
// Maps a register code plus enable to the one-hot register file selects,
// and flags whether the code names a real register.
module rf_sel_decode
    import rf_xfer_ctrl_pkg::*;
(
    input  logic [2:0] code_i,
    input  logic       en_i,
    output logic       as_o,
    output logic       bs_o,
    output logic       cs_o,
    output logic       ds_o,
    output logic       fs_o,
    output logic       legal_o
);

    always_comb begin
        as_o    = 1'b0;
        bs_o    = 1'b0;
        cs_o    = 1'b0;
        ds_o    = 1'b0;
        fs_o    = 1'b0;
        legal_o = reg_legal(code_i);
        if (en_i) begin
            case (code_i)
                REG_A:   as_o = 1'b1;
                REG_B:   bs_o = 1'b1;
                REG_C:   cs_o = 1'b1;
                REG_D:   ds_o = 1'b1;
                REG_F:   fs_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rf_xfer_ctrl.sv
// Register-transfer initiator: accepts MOV/LDI/RD/SWP commands and sequences
// the register file selects, read/write enables and write data.
module rf_xfer_ctrl
    import rf_xfer_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter logic [2:0]  FREG  = rf_xfer_ctrl_pkg::FREG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_src,
    input  logic [2:0]       cmd_dst,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             res_valid,
    output logic             res_err,
    output logic [WIDTH-1:0] res_data,
    output logic [WIDTH-1:0] rf_d,
    output logic             rf_as,
    output logic             rf_bs,
    output logic             rf_cs,
    output logic             rf_ds,
    output logic             rf_fs,
    output logic             rf_re,
    output logic             rf_we,
    input  logic [WIDTH-1:0] rf_p,
    input  logic [WIDTH-1:0] rf_fo
);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [2:0]       src_q, src_d;
    logic [2:0]       dst_q, dst_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] t0_q, t0_d;
    logic [WIDTH-1:0] t1_q, t1_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             err_q, err_d;

    logic [2:0]       dec_code;
    logic             dec_en;
    logic             dec_legal;
    logic [2:0]       rd_code;
    logic [WIDTH-1:0] rd_sample;
    logic [WIDTH-1:0] wr_data;
    logic             src_bad;
    logic             dst_bad;

    // In IDLE the decoder sees the incoming dst with selects disabled, so its
    // legal flag doubles as the dst check at acceptance.
    always_comb begin
        dec_code = cmd_dst;
        dec_en   = 1'b0;
        unique case (state_q)
            StRdSrc, StWrSrc: begin
                dec_code = src_q;
                dec_en   = ~rst;
            end
            StRdDst, StWrDst: begin
                dec_code = dst_q;
                dec_en   = ~rst;
            end
            default: ;
        endcase
    end

    rf_sel_decode u_sel_decode (
        .code_i  (dec_code),
        .en_i    (dec_en),
        .as_o    (rf_as),
        .bs_o    (rf_bs),
        .cs_o    (rf_cs),
        .ds_o    (rf_ds),
        .fs_o    (rf_fs),
        .legal_o (dec_legal)
    );

    assign rd_code   = (state_q == StRdDst) ? dst_q : src_q;
    assign rd_sample = (rd_code == FREG) ? rf_fo : rf_p;
    assign wr_data   = (state_q == StWrSrc) ? t1_q : ((op_q == OP_LDI) ? imm_q : t0_q);

    assign src_bad = (cmd_op != OP_LDI) && !reg_legal(cmd_src);
    assign dst_bad = (cmd_op != OP_RD) && !dec_legal;

    // Reset gates the strobes combinationally so an abort never writes.
    assign cmd_ready = (state_q == StIdle) && !rst;
    assign res_valid = (state_q == StDone) && !rst;
    assign res_err   = res_valid && err_q;
    assign res_data  = res_data_q;
    assign rf_re     = !rst && ((state_q == StRdSrc) || (state_q == StRdDst));
    assign rf_we     = !rst && ((state_q == StWrDst) || (state_q == StWrSrc));
    assign rf_d      = rf_we ? wr_data : '0;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        src_d      = src_q;
        dst_d      = dst_q;
        imm_d      = imm_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        res_data_d = res_data_q;
        err_d      = err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    op_d  = cmd_op;
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    imm_d = cmd_imm;
                    if (src_bad || dst_bad) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (cmd_op == OP_LDI) ? StWrDst : StRdSrc;
                    end
                end
            end
            StRdSrc: begin
                t0_d = rd_sample;
                unique case (op_q)
                    OP_RD: begin
                        res_data_d = rd_sample;
                        state_d    = StDone;
                    end
                    OP_SWP:  state_d = StRdDst;
                    default: state_d = StWrDst;
                endcase
            end
            StRdDst: begin
                t1_d    = rd_sample;
                state_d = StWrDst;
            end
            StWrDst: begin
                if (op_q == OP_SWP) begin
                    state_d = StWrSrc;
                end else begin
                    res_data_d = wr_data;
                    state_d    = StDone;
                end
            end
            StWrSrc: begin
                res_data_d = t0_q;
                state_d    = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= OP_MOV;
            src_q      <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
            t0_q       <= '0;
            t1_q       <= '0;
            res_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            imm_q      <= imm_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            res_data_q <= res_data_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_rf_xfer_ctrl.sv
// Randomized self-checking bench for rf_xfer_ctrl with a register file
// environment and a command-level reference model.
module tb_rf_xfer_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [2:0]   cmd_src = 3'd0;
    logic [2:0]   cmd_dst = 3'd0;
    logic [W-1:0] cmd_imm = '0;
    logic         res_valid, res_err;
    logic [W-1:0] res_data, rf_d;
    logic         rf_as, rf_bs, rf_cs, rf_ds, rf_fs, rf_re, rf_we;
    logic [W-1:0] rf_p, rf_fo;

    logic [W-1:0] rf_mem  [5];
    logic [W-1:0] ref_mem [5];
    logic [W-1:0] noise = 8'h5C;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_xfer_ctrl #(.WIDTH(W), .FREG(3'd4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_imm   (cmd_imm),
        .res_valid (res_valid),
        .res_err   (res_err),
        .res_data  (res_data),
        .rf_d      (rf_d),
        .rf_as     (rf_as),
        .rf_bs     (rf_bs),
        .rf_cs     (rf_cs),
        .rf_ds     (rf_ds),
        .rf_fs     (rf_fs),
        .rf_re     (rf_re),
        .rf_we     (rf_we),
        .rf_p      (rf_p),
        .rf_fo     (rf_fo)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register file environment: unselected bus lanes carry random noise.
    always_comb begin
        rf_p  = noise;
        rf_fo = ~noise;
        if (rf_re) begin
            if (rf_as) rf_p = rf_mem[0];
            if (rf_bs) rf_p = rf_mem[1];
            if (rf_cs) rf_p = rf_mem[2];
            if (rf_ds) rf_p = rf_mem[3];
            if (rf_fs) rf_fo = rf_mem[4];
        end
    end

    always @(posedge clk) begin
        if (rf_we) begin
            if (rf_as) rf_mem[0] = rf_d;
            if (rf_bs) rf_mem[1] = rf_d;
            if (rf_cs) rf_mem[2] = rf_d;
            if (rf_ds) rf_mem[3] = rf_d;
            if (rf_fs) rf_mem[4] = rf_d;
        end
        noise <= 8'($urandom);
    end

    function automatic int sel_count();
        return int'(rf_as) + int'(rf_bs) + int'(rf_cs) + int'(rf_ds) + int'(rf_fs);
    endfunction

    function automatic logic [2:0] sel_code();
        if (rf_as) return 3'd0;
        if (rf_bs) return 3'd1;
        if (rf_cs) return 3'd2;
        if (rf_ds) return 3'd3;
        if (rf_fs) return 3'd4;
        return 3'd7;
    endfunction

    function automatic logic [11:0] enc(input logic we, input logic [2:0] c, input logic [7:0] d);
        return {we, c, (we ? d : 8'h00)};
    endfunction

    always @(negedge clk) begin
        check_val("onehot", 32'(sel_count() <= 1), 32'd1);
        check_val("re_we_excl", 32'(rf_re && rf_we), 32'd0);
        if (!rf_we) check_val("rf_d_zero", 32'(rf_d), 32'd0);
        if (!rf_re && !rf_we) check_val("sel_idle", 32'(sel_count()), 32'd0);
        if (!res_valid) check_val("err_outside_done", 32'(res_err), 32'd0);
    end

    task automatic preset(input int r, input logic [7:0] v);
        rf_mem[r]  = v;
        ref_mem[r] = v;
    endtask

    // Issue one command starting at a negedge; returns at the negedge of its DONE cycle.
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                          input logic [7:0] imm, input bit keep, output int waits);
        logic [11:0] exp_q[$];
        logic [11:0] obs_q[$];
        logic [7:0]  a, b, exp_res;
        logic        exp_err;
        int          exp_lat, lat;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = s;
        cmd_dst   = d;
        cmd_imm   = imm;
        waits     = 0;
        while (!cmd_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check_val("accept_timeout", 32'(cmd_ready), 32'd1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        check_val("idle_res_valid", 32'(res_valid), 32'd0);

        exp_err = ((op != 2'd1) && (s > 3'd4)) || ((op != 2'd2) && (d > 3'd4));
        exp_res = 8'h00;
        exp_lat = 1;
        if (!exp_err) begin
            case (op)
                2'd0: begin
                    a = ref_mem[s];
                    exp_q.push_back(enc(1'b0, s, 8'h00));
                    exp_q.push_back(enc(1'b1, d, a));
                    ref_mem[d] = a;
                    exp_res = a;
                    exp_lat = 3;
                end
                2'd1: begin
                    exp_q.push_back(enc(1'b1, d, imm));
                    ref_mem[d] = imm;
                    exp_res = imm;
                    exp_lat = 2;
                end
                2'd2: begin
                    exp_q.push_back(enc(1'b0, s, 8'h00));
                    exp_res = ref_mem[s];
                    exp_lat = 2;
                end
                default: begin
                    a = ref_mem[s];
                    b = ref_mem[d];
                    exp_q.push_back(enc(1'b0, s, 8'h00));
                    exp_q.push_back(enc(1'b0, d, 8'h00));
                    exp_q.push_back(enc(1'b1, d, a));
                    exp_q.push_back(enc(1'b1, s, b));
                    ref_mem[d] = a;
                    ref_mem[s] = b;
                    exp_res = a;
                    exp_lat = 5;
                end
            endcase
        end

        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
        lat = 1;
        for (int k = 0; k < 12; k++) begin
            if (rf_re || rf_we) obs_q.push_back(enc(rf_we, sel_code(), rf_d));
            check_val("busy_ready", 32'(cmd_ready), 32'd0);
            if (res_valid) break;
            @(negedge clk);
            lat++;
        end
        check_val("done_seen", 32'(res_valid), 32'd1);
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("res_err", 32'(res_err), 32'(exp_err));
        if (!exp_err) check_val("res_data", 32'(res_data), 32'(exp_res));
        check_val("n_access", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_val("access", 32'(obs_q[i]), 32'(exp_q[i]));
        for (int r = 0; r < 5; r++) check_val("regfile", 32'(rf_mem[r]), 32'(ref_mem[r]));
    endtask

    function automatic logic [2:0] rand_code();
        if ($urandom_range(0, 7) == 0) return 3'($urandom_range(5, 7));
        return 3'($urandom_range(0, 4));
    endfunction

    initial begin
        int  w;
        bit  keep;
        for (int r = 0; r < 5; r++) preset(r, 8'($urandom));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", 32'(cmd_ready), 32'd0);
        check_val("rst_res_valid", 32'(res_valid), 32'd0);
        check_val("rst_res_err", 32'(res_err), 32'd0);
        check_val("rst_res_data", 32'(res_data), 32'd0);
        check_val("rst_rf_d", 32'(rf_d), 32'd0);
        check_val("rst_re_we", 32'({rf_re, rf_we}), 32'd0);
        check_val("rst_sel", 32'(sel_count()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Directed cases
        do_cmd(2'd1, 3'd0, 3'd1, 8'h5A, 1'b0, w);
        preset(4, 8'h81);
        do_cmd(2'd0, 3'd4, 3'd2, 8'h00, 1'b0, w);
        preset(0, 8'h11);
        preset(3, 8'h22);
        do_cmd(2'd3, 3'd0, 3'd3, 8'h00, 1'b0, w);
        do_cmd(2'd0, 3'd6, 3'd0, 8'h00, 1'b0, w);
        do_cmd(2'd1, 3'd7, 3'd2, 8'hC3, 1'b0, w);
        do_cmd(2'd2, 3'd1, 3'd5, 8'h00, 1'b0, w);
        do_cmd(2'd3, 3'd2, 3'd2, 8'h00, 1'b0, w);
        do_cmd(2'd0, 3'd3, 3'd3, 8'h00, 1'b0, w);
        do_cmd(2'd2, 3'd0, 3'd0, 8'h00, 1'b1, w);
        do_cmd(2'd2, 3'd1, 3'd0, 8'h00, 1'b0, w);
        check_val("b2b_wait", 32'(w), 32'd1);

        // Reset in the middle of a SWP, during its second read
        preset(0, 8'h33);
        preset(3, 8'h44);
        @(negedge clk);
        cmd_op = 2'd3;
        cmd_src = 3'd0;
        cmd_dst = 3'd3;
        cmd_valid = 1'b1;
        check_val("swp_rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_val("swp_rst_rdsrc", 32'({rf_re, rf_as}), 32'd3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_sel", 32'(sel_count()), 32'd0);
        check_val("abort_re_we", 32'({rf_re, rf_we}), 32'd0);
        check_val("abort_res_valid", 32'(res_valid), 32'd0);
        check_val("abort_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("abort_ready_after", 32'(cmd_ready), 32'd1);
        check_val("abort_no_valid", 32'(res_valid), 32'd0);
        for (int r = 0; r < 5; r++) check_val("abort_regfile", 32'(rf_mem[r]), 32'(ref_mem[r]));

        // Randomized commands
        for (int n = 0; n < 80; n++) begin
            keep = (n != 79) && ($urandom_range(0, 1) == 1);
            do_cmd(2'($urandom_range(0, 3)), rand_code(), rand_code(), 8'($urandom), keep, w);
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_xfer_ctrl.md
Name: rf_xfer_ctrl

Overview:
- Initiator for the 8-bit register file select interface.
- Accepts one register-transfer command at a time over a valid/ready handshake.
- Sequences the register file's one-hot selects (as/bs/cs/ds/fs), read-enable and write-enable, plus its data input, through read and write cycles.
- Returns read data and completion status. Sits between the instruction decoder and the register file, so the decoder never drives selects directly.

Parameters:
- WIDTH, 8, data width of register file words and immediates.
- FREG, 4, register code of the flags register F; its reads are sampled from rf_fo, not rf_p.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_op  in  2  0=MOV src->dst, 1=LDI imm->dst, 2=RD src->result, 3=SWP src<->dst.
- cmd_src  in  3  source register code: 0=A, 1=B, 2=C, 3=D, 4=F; 5-7 illegal.
- cmd_dst  in  3  destination register code, same encoding.
- cmd_imm  in  WIDTH  immediate for LDI.
- res_valid  out  1  one-cycle completion pulse.
- res_err  out  1  qualifies res_valid; command had an illegal register code.
- res_data  out  WIDTH  RD: value read; MOV/SWP: value written to dst; LDI: imm.
- rf_d  out  WIDTH  register file write data.
- rf_as, rf_bs, rf_cs, rf_ds, rf_fs  out  1 each  one-hot register selects.
- rf_re  out  1  register file read enable.
- rf_we  out  1  register file write enable.
- rf_p  in  WIDTH  register file read bus (A-D).
- rf_fo  in  WIDTH  register file flags output (F when F is selected with re).

Behaviour:
- Reset (rst=1 at edge): state=IDLE. After the edge, and while rst is held, cmd_ready=0, res_valid=0, res_err=0, res_data=0, rf_d=0, all selects 0, rf_re=0, rf_we=0, captured temps t0 and t1=0.
- Reset asserted mid-command aborts the command immediately. No further rf_we occurs and no res_valid is issued.
- cmd_ready=1 only in IDLE with rst=0. A command is accepted on an edge with cmd_valid&cmd_ready; op, src, dst and imm are latched.
- States: IDLE, RD_SRC, RD_DST, WR_DST, WR_SRC, DONE.
- Outputs are decoded from state and latched fields:
  - at most one select high;
  - rf_re high only in RD_*; rf_we high only in WR_*; never both;
  - selects are all 0 in IDLE and DONE.
- Read sampling: in RD_x the selected register's value is captured at the end of the cycle. It comes from rf_fo if the code == FREG, else from rf_p.
- Transitions:
  - MOV: IDLE->RD_SRC (t0 captured)->WR_DST (rf_d=t0)->DONE.
  - LDI: IDLE->WR_DST (rf_d=imm)->DONE.
  - RD: IDLE->RD_SRC->DONE.
  - SWP: IDLE->RD_SRC (t0)->RD_DST (t1)->WR_DST (rf_d=t0)->WR_SRC (rf_d=t1)->DONE.
  - Illegal src (when used) or dst code: IDLE->DONE with res_err=1 and no rf access.
- DONE lasts exactly 1 cycle: res_valid=1 and res_data/res_err valid, then IDLE. res_data holds its value until the next DONE; res_valid and res_err are 0 outside DONE.
- Back-to-back throughput: the next command is accepted in the IDLE cycle after DONE.
- Busy cycles from acceptance to res_valid: LDI 2, RD 2, MOV 3, SWP 5, illegal 1.
- src==dst is legal:
  - MOV rewrites the same value;
  - SWP performs all four cycles and leaves the register unchanged.
- LDI ignores cmd_src; RD ignores cmd_dst. An illegal code in an ignored field is not an error.
- rf_d is 0 whenever rf_we=0.

Decomposition:
- Shared package: register code constants (REG_A..REG_F, FREG), op encodings (OP_MOV, OP_LDI, OP_RD, OP_SWP), state encoding.
- One sub-module, rf_sel_decode: maps a 3-bit code plus enable to the five one-hot selects and a legal flag. It is instantiated once and fed the code the current state needs.

Test Plan:
- Reset: hold rst 3 cycles mid-SWP (in RD_DST) -> selects/re/we/res_valid all 0 in the cycle after the first reset edge; cmd_ready=1 one cycle after rst drops; register model shows no write.
- LDI dst=B imm=0x5A -> next cycle rf_bs=1, rf_we=1, rf_d=0x5A; following cycle res_valid=1, res_data=0x5A; total 2 busy cycles.
- MOV src=F dst=C with rf_fo=0x81, rf_p=0x00 -> RD_SRC rf_fs=1, rf_re=1; WR_DST rf_cs=1, rf_d=0x81; res_data=0x81.
- SWP A=0x11, D=0x22 -> read A, read D, write D=0x11, write A=0x22 in that order; res_valid on 5th cycle after accept, res_data=0x11.
- Illegal: MOV src=6 dst=A -> next cycle res_valid=1, res_err=1; no rf_re/rf_we asserted at any point.
- Back-to-back RD A then RD B with cmd_valid held -> second accept in the IDLE cycle after the first DONE; cmd_ready=0 in all other cycles.
